spi_master_arbiter: RTL and testbench

- Shares one spi_master instance between N_REQ requesters.
- Round-robin arbitration; each granted request is one complete 32-bit SPI exchange.
- Drives the spi_master register port (address/data_in/sel/read/write): writes the TX word, waits for completion, reads the RX word, returns it to the winner with a one-cycle ack.
- Sits between the system bus clients and spi_master in the clk domain.

---
 rtl/spi_master_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master register port between N_REQ requesters.
// Optional macro SPI_ARB_IRQ_EN: detect completion from m_interrupt instead of polling SPI_READY.

`ifndef SPI_INTRRPT_EN
`define SPI_INTRRPT_EN 3'd1
`endif
`ifndef SPI_READY
`define SPI_READY 3'd2
`endif
`ifndef SPI_TX
`define SPI_TX 3'd3
`endif
`ifndef SPI_RX
`define SPI_RX 3'd4
`endif

module spi_master_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int POLL_GAP = 4
) (
    input  logic                    clk,
    input  logic                    rst_int,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    busy,
    output logic [ADDR_W-1:0]       m_address,
    output logic [DATA_W-1:0]       m_data_in,
    input  logic [DATA_W-1:0]       m_data_out,
    output logic                    m_sel,
    output logic                    m_read,
    output logic                    m_write,
    input  logic                    m_interrupt
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [ADDR_W-1:0] A_INTRRPT_EN = ADDR_W'(`SPI_INTRRPT_EN);
    localparam logic [ADDR_W-1:0] A_READY      = ADDR_W'(`SPI_READY);
    localparam logic [ADDR_W-1:0] A_TX         = ADDR_W'(`SPI_TX);
    localparam logic [ADDR_W-1:0] A_RX         = ADDR_W'(`SPI_RX);

    typedef enum logic [2:0] {
        S_IDLE, S_TX, S_GAP, S_POLL, S_RX, S_ACK, S_INIT, S_WAIT_IRQ
    } state_t;

`ifdef SPI_ARB_IRQ_EN
    localparam state_t RESET_STATE = S_INIT;
    localparam int unused_poll_gap = POLL_GAP;
`else
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);
    logic [7:0] gap_cnt, gap_d;
    logic       unused_irq;
    assign unused_irq = m_interrupt;
`endif

    state_t             state, next_state;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d, winner, winner_d, grant_idx, cand;
    logic               grant_vld;
    logic [DATA_W-1:0]  wdata_q, wdata_d, rsp_d, m_data_in_d;
    logic [ADDR_W-1:0]  m_address_d;
    logic               m_sel_d, m_read_d, m_write_d;
    logic [N_REQ-1:0]   ack_d;

    assign busy = (state != S_IDLE);

    // First requesting index after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        next_state = state;
        rr_ptr_d   = rr_ptr;
        winner_d   = winner;
        wdata_d    = wdata_q;
        rsp_d      = rsp_rdata;
`ifndef SPI_ARB_IRQ_EN
        gap_d      = gap_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    winner_d   = grant_idx;
                    rr_ptr_d   = grant_idx;
                    wdata_d    = req_wdata[grant_idx*DATA_W +: DATA_W];
                    next_state = S_TX;
                end
            end
`ifdef SPI_ARB_IRQ_EN
            S_INIT:     if (m_sel) next_state = S_IDLE;
            S_TX:       next_state = S_WAIT_IRQ;
            S_WAIT_IRQ: if (m_interrupt) next_state = S_RX;
`else
            S_TX: begin
                gap_d      = GAP_LOAD;
                next_state = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == 8'd0) next_state = S_POLL;
                else                 gap_d = gap_cnt - 8'd1;
            end
            S_POLL: begin
                if (m_data_out[0]) begin
                    next_state = S_RX;
                end else begin
                    gap_d      = GAP_LOAD;
                    next_state = S_GAP;
                end
            end
`endif
            S_RX: begin
                rsp_d      = m_data_out;
                next_state = S_ACK;
            end
            S_ACK:   next_state = S_IDLE;
            default: next_state = RESET_STATE;
        endcase
    end

    // Bus strobes are decoded from the state being entered so the registered outputs line up with it.
    always_comb begin
        m_sel_d     = 1'b0;
        m_read_d    = 1'b0;
        m_write_d   = 1'b0;
        m_address_d = '0;
        m_data_in_d = '0;
        ack_d       = '0;
        case (next_state)
            S_TX: begin
                m_sel_d     = 1'b1;
                m_write_d   = 1'b1;
                m_address_d = A_TX;
                m_data_in_d = wdata_d;
            end
            S_RX: begin
                m_sel_d     = 1'b1;
                m_read_d    = 1'b1;
                m_address_d = A_RX;
            end
            S_ACK: ack_d[winner_d] = 1'b1;
`ifdef SPI_ARB_IRQ_EN
            S_INIT: begin
                m_sel_d     = 1'b1;
                m_write_d   = 1'b1;
                m_address_d = A_INTRRPT_EN;
                m_data_in_d = DATA_W'(1);
            end
`else
            S_POLL: begin
                m_sel_d     = 1'b1;
                m_read_d    = 1'b1;
                m_address_d = A_READY;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state     <= RESET_STATE;
            rr_ptr    <= IDX_W'(N_REQ - 1);
            winner    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            ack       <= '0;
            m_sel     <= 1'b0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            m_address <= '0;
            m_data_in <= '0;
`ifndef SPI_ARB_IRQ_EN
            gap_cnt   <= 8'd0;
`endif
        end else begin
            state     <= next_state;
            rr_ptr    <= rr_ptr_d;
            winner    <= winner_d;
            wdata_q   <= wdata_d;
            rsp_rdata <= rsp_d;
            ack       <= ack_d;
            m_sel     <= m_sel_d;
            m_read    <= m_read_d;
            m_write   <= m_write_d;
            m_address <= m_address_d;
            m_data_in <= m_data_in_d;
`ifndef SPI_ARB_IRQ_EN
            gap_cnt   <= gap_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a behavioural spi_master register model.
// Define SPI_ARB_IRQ_EN for both files to exercise the interrupt-driven build.

module tb_spi_master_arbiter;
    localparam int N_REQ    = 2;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int POLL_GAP = 4;
    localparam int XFER     = 40;

    localparam logic [ADDR_W-1:0] A_INT   = 3'd1;
    localparam logic [ADDR_W-1:0] A_READY = 3'd2;
    localparam logic [ADDR_W-1:0] A_TX    = 3'd3;
    localparam logic [ADDR_W-1:0] A_RX    = 3'd4;

`ifdef SPI_ARB_IRQ_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_int = 1'b1;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*DATA_W-1:0] req_wdata = '0;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    busy;
    logic [ADDR_W-1:0]       m_address;
    logic [DATA_W-1:0]       m_data_in;
    logic [DATA_W-1:0]       m_data_out;
    logic                    m_sel, m_read, m_write;
    logic                    m_interrupt;

    spi_master_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk), .rst_int(rst_int), .req(req), .req_wdata(req_wdata),
        .ack(ack), .rsp_rdata(rsp_rdata), .busy(busy),
        .m_address(m_address), .m_data_in(m_data_in), .m_data_out(m_data_out),
        .m_sel(m_sel), .m_read(m_read), .m_write(m_write), .m_interrupt(m_interrupt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    bit first_op_pending = 1'b0;

    typedef struct {
        logic [N_REQ-1:0]  ack;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] tx_q[$];
    logic [DATA_W-1:0] rx_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // spi_master model: TX write starts a transfer that sets ready XFER cycles later; RX read clears it.
    logic              sl_ready, sl_busy, sl_irq_en;
    int                sl_cnt;
    logic [DATA_W-1:0] sl_rx;

    always @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            sl_ready  <= 1'b0;
            sl_busy   <= 1'b0;
            sl_irq_en <= 1'b0;
            sl_cnt    <= 0;
            sl_rx     <= '0;
        end else begin
            if (m_sel && m_write && m_address == A_TX) begin
                sl_busy <= 1'b1;
                sl_cnt  <= XFER;
                sl_rx   <= (rx_q.size() > 0) ? rx_q.pop_front() : 32'hDEAD_BEEF;
            end else if (sl_busy) begin
                if (sl_cnt == 1) begin
                    sl_ready <= 1'b1;
                    sl_busy  <= 1'b0;
                end else begin
                    sl_cnt <= sl_cnt - 1;
                end
            end
            if (m_sel && m_read && m_address == A_RX) sl_ready <= 1'b0;
            if (m_sel && m_write && m_address == A_INT) sl_irq_en <= m_data_in[0];
        end
    end

    assign m_interrupt = sl_ready & sl_irq_en;

    always_comb begin
        m_data_out = '0;
        if (m_address == A_READY) m_data_out = {31'd0, sl_ready};
        else if (m_address == A_RX) m_data_out = sl_rx;
    end

    // Monitor: compares every bus operation and every ack against the queues filled by the stimulus.
    always @(negedge clk) begin : monitor
        exp_t              e;
        logic [DATA_W-1:0] txe;
        static int         last_poll = -1;
        static int         last_rdy = -100;
        static int         rx_reads = 0;
        static int         irq_rise = -100;
        static logic       prev_irq = 1'b0;
        static logic [DATA_W-1:0] last_rsp = '0;
        if (rst_int) begin
            last_poll = -1;
            last_rdy  = -100;
            rx_reads  = 0;
            prev_irq  = 1'b0;
            last_rsp  = '0;
        end else begin
            if (m_interrupt && !prev_irq) irq_rise = cyc;
            prev_irq = m_interrupt;

            if (m_sel && first_op_pending) begin
                first_op_pending = 1'b0;
`ifdef SPI_ARB_IRQ_EN
                check("first_op_init", 64'({m_write, m_address, m_data_in}), 64'({1'b1, A_INT, 32'd1}));
`else
                check("first_op_tx", 64'({m_write, m_address}), 64'({1'b1, A_TX}));
`endif
            end

            if (m_sel && m_write && m_address == A_TX) begin
                txe = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
                check("tx_word", 64'(m_data_in), 64'(txe));
                last_poll = -1;
                last_rdy  = -100;
                rx_reads  = 0;
            end

            if (m_sel && m_read && m_address == A_READY) begin
`ifdef SPI_ARB_IRQ_EN
                check("ready_poll_in_irq_mode", 64'(m_read), 64'(0));
`else
                if (last_poll >= 0) check("poll_spacing", 64'(cyc - last_poll), 64'(POLL_GAP + 1));
                last_poll = cyc;
                if (m_data_out[0]) last_rdy = cyc;
`endif
            end

            if (m_sel && m_read && m_address == A_RX) begin
                rx_reads++;
`ifndef SPI_ARB_IRQ_EN
                check("rx_after_ready_poll", 64'(cyc - last_rdy), 64'(1));
`endif
            end

            if (ack != '0) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e.ack   = '0;
                    e.rdata = 'x;
                end
                check("ack_onehot", 64'(ack), 64'(e.ack));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rx_reads_per_xfer", 64'(rx_reads), 64'(1));
                check("busy_in_ack", 64'(busy), 64'(1));
`ifdef SPI_ARB_IRQ_EN
                check("irq_to_ack", 64'(cyc - irq_rise), 64'(2));
`endif
                last_rsp = rsp_rdata;
            end else begin
                check("rsp_hold", 64'(rsp_rdata), 64'(last_rsp));
            end
        end
    end

    task automatic push_xfer(input int idx, input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] rx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        tx_q.push_back(tx);
        rx_q.push_back(rx);
        exp_q.push_back('{ack: oh, rdata: rx});
    endtask

    task automatic wait_acks(input int n, input int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (ack != '0) seen++;
        end
        check("ack_count_within_budget", 64'(seen), 64'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_int = 1'b1;
        @(negedge clk);
        rst_int = 1'b0;
        first_op_pending = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 64'(ack), 64'(0));
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(BUSY_RST));
        check({tag, "_m_strobes"}, 64'({m_sel, m_read, m_write}), 64'(0));
        check({tag, "_m_address"}, 64'(m_address), 64'(0));
        check({tag, "_m_data_in"}, 64'(m_data_in), 64'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t;
        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_int = 1'b0;
        first_op_pending = 1'b1;

        // Single request from requester 0.
        req_wdata = {32'h0000_0000, 32'hA5A5_1234};
        push_xfer(0, 32'hA5A5_1234, 32'h0F0F_CAFE);
        req = 2'b01;
        wait_acks(1, 200);
        req = '0;
        @(negedge clk);
        check("busy_after_ack", 64'(busy), 64'(0));

        // Contention from a fresh reset: requester 0 wins first, then strict alternation.
        do_reset();
        req_wdata = {32'h2222_0001, 32'h1111_0000};
        push_xfer(0, 32'h1111_0000, 32'hC0DE_0000);
        push_xfer(1, 32'h2222_0001, 32'hC0DE_0001);
        push_xfer(0, 32'h1111_0000, 32'hC0DE_0002);
        push_xfer(1, 32'h2222_0001, 32'hC0DE_0003);
        req = 2'b11;
        wait_acks(4, 400);
        req = '0;

        // Single-cycle request pulse still completes.
        @(negedge clk);
        req_wdata = {32'hDEC0_0001, 32'h0000_0000};
        push_xfer(1, 32'hDEC0_0001, 32'h3333_4444);
        req = 2'b10;
        @(negedge clk);
        req = '0;
        wait_acks(1, 200);

        // Reset while waiting for completion: no ack, outputs back to reset values.
        @(negedge clk);
        req_wdata = {32'h0000_0000, 32'h7777_8888};
        tx_q.push_back(32'h7777_8888);
        rx_q.push_back(32'hBAD0_BAD0);
        req = 2'b01;
        t = 0;
        while (!(m_sel && m_write && m_address == A_TX) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("tx_issued_before_reset", 64'(t < 50), 64'(1));
        req = '0;
        repeat (2) @(negedge clk);
        check("busy_while_waiting", 64'(busy), 64'(1));
        rst_int = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_int = 1'b0;
        first_op_pending = 1'b1;
        repeat (60) @(negedge clk);

        // Service after the abandoned transfer; rr_ptr is back to N_REQ-1.
        req_wdata = {32'h1357_9BDF, 32'h0000_0000};
        push_xfer(1, 32'h1357_9BDF, 32'h2468_ACE0);
        req = 2'b10;
        wait_acks(1, 200);
        req = '0;
        repeat (3) @(negedge clk);

        check("exp_queue_drained", 64'(exp_q.size()), 64'(0));
        check("tx_queue_drained", 64'(tx_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
